// File: rtl/steer_en_sm.sv
// Steering-enable state machine: qualifies rider presence and balance from load cells.
// Optional macro STEER_DIFF_FILT_EN filters the STEER_EN->WAIT exit over two samples.
module steer_en_sm #(
    parameter int          fast_sim     = 1,
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int TW = (fast_sim != 0) ? 15 : 26;
    localparam logic [12:0] HI_THR = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
    localparam logic [12:0] LO_THR = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_STEER = 2'd2;

    logic [11:0]   r_lft;
    logic [11:0]   r_rght;
    logic [TW-1:0] r_tmr;
    logic [1:0]    r_state;
    logic          r_en_steer;
    logic          r_rider_off;

    logic [12:0] w_sum;
    logic [11:0] w_diff;
    logic [12:0] w_diff13;
    logic        w_sum_gt_min;
    logic        w_sum_lt_min;
    logic        w_diff_gt_1_4;
    logic        w_diff_gt_15_16;
    logic        w_tmr_full;
    logic        w_clr_tmr;
    logic        w_steer_exit;
    logic [1:0]  w_state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lft  <= '0;
            r_rght <= '0;
        end else if (vld) begin
            r_lft  <= lft_ld;
            r_rght <= rght_ld;
        end
    end

    assign w_sum    = {1'b0, r_lft} + {1'b0, r_rght};
    assign w_diff   = (r_lft >= r_rght) ? (r_lft - r_rght) : (r_rght - r_lft);
    assign w_diff13 = {1'b0, w_diff};

    assign w_sum_gt_min    = (w_sum > HI_THR);
    assign w_sum_lt_min    = (w_sum < LO_THR);
    assign w_diff_gt_1_4   = (w_diff13 > (w_sum >> 2));
    // sum - sum/16 can never underflow, so 13 bits suffice.
    assign w_diff_gt_15_16 = (w_diff13 > (w_sum - (w_sum >> 4)));

    assign w_tmr_full = &r_tmr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr <= '0;
        end else if (w_clr_tmr) begin
            r_tmr <= '0;
        end else if (!w_tmr_full) begin
            r_tmr <= r_tmr + TW'(1);
        end
    end

`ifdef STEER_DIFF_FILT_EN
    logic r_new_samp;
    logic r_diff_flag;

    // r_new_samp marks the cycle in which a freshly captured sample is visible.
    assign w_steer_exit = w_diff_gt_15_16 & r_new_samp & r_diff_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_new_samp  <= 1'b0;
            r_diff_flag <= 1'b0;
        end else begin
            r_new_samp <= vld;
            if ((r_state != S_STEER) || (w_state_next != S_STEER)) begin
                r_diff_flag <= 1'b0;
            end else if (r_new_samp) begin
                r_diff_flag <= w_diff_gt_15_16;
            end
        end
    end
`else
    assign w_steer_exit = w_diff_gt_15_16;
`endif

    always_comb begin
        w_state_next = r_state;
        w_clr_tmr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sum_gt_min) begin
                    w_state_next = S_WAIT;
                    w_clr_tmr    = 1'b1;
                end
            end
            S_WAIT: begin
                if (w_sum_lt_min) begin
                    w_state_next = S_IDLE;
                end else if (w_diff_gt_1_4) begin
                    w_clr_tmr = 1'b1;
                end else if (w_tmr_full) begin
                    w_state_next = S_STEER;
                end
            end
            S_STEER: begin
                if (w_sum_lt_min) begin
                    w_state_next = S_IDLE;
                end else if (w_steer_exit) begin
                    w_state_next = S_WAIT;
                    w_clr_tmr    = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_en_steer  <= 1'b0;
            r_rider_off <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_en_steer  <= (w_state_next == S_STEER);
            r_rider_off <= (w_state_next == S_IDLE);
        end
    end

    assign en_steer  = r_en_steer;
    assign rider_off = r_rider_off;

endmodule
